// File: rtl/spi_frame_engine_if.sv
// SPI pins and register-bank bus for the SPI target frame engine.
// The slave modport is the engine side; master is the pad/register side.
interface spi_frame_engine_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  spi_cs_n;
  logic                  spi_clk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [REG_WIDTH-1:0]  wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [REG_WIDTH-1:0]  rd_data;
  logic                  frame_err;

  modport slave (
    input  spi_cs_n,
    input  spi_clk,
    input  spi_mosi,
    input  rd_data,
    output spi_miso,
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    output frame_err
  );

  modport master (
    output spi_cs_n,
    output spi_clk,
    output spi_mosi,
    output rd_data,
    input  spi_miso,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    input  frame_err
  );
endinterface

// File: rtl/spi_frame_engine.sv
// SPI target frame engine: command byte + data byte, register write
// strobe on write frames, status word shifted out MSB-first on reads.
module spi_frame_engine #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [1:0]              mode,
  spi_frame_engine_if.slave       bus
);

  localparam int CW = $clog2(REG_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(REG_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RDLOAD,
    S_DATA,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  sclk_q, sclk_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  armed_q, armed_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [REG_WIDTH-1:0]  rx_q, rx_d;
  logic [REG_WIDTH-1:0]  tx_q, tx_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  err_q, err_d;

  logic                  rise;
  logic                  fall;
  logic                  smp;
  logic                  sft;
  logic                  last;
  logic [REG_WIDTH-1:0]  rx_nxt;

  assign rise   = bus.spi_clk & ~sclk_q;
  assign fall   = ~bus.spi_clk & sclk_q;
  assign smp    = (cpol_q == cpha_q) ? rise : fall;
  assign sft    = (cpol_q == cpha_q) ? fall : rise;
  assign last   = (bit_cnt_q == LAST);
  assign rx_nxt = {rx_q[REG_WIDTH-2:0], bus.spi_mosi};

  always_comb begin
    state_d   = state_q;
    sclk_d    = bus.spi_clk;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    armed_d   = armed_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    if (ena) begin
      // A new frame needs cs_n seen high first (e.g. after a mid-frame reset).
      if (bus.spi_cs_n) armed_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (!bus.spi_cs_n && armed_q) begin
            state_d   = S_CMD;
            cpol_d    = mode[1];
            cpha_d    = mode[0];
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
          end
        end
        S_CMD: begin
          if (bus.spi_cs_n) begin
            state_d = S_IDLE;
            err_d   = (bit_cnt_q != '0);
          end else if (smp) begin
            rx_d      = rx_nxt;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (last) begin
              rw_d      = rx_nxt[REG_WIDTH-1];
              addr_d    = rx_nxt[ADDR_WIDTH-1:0];
              rd_addr_d = rx_nxt[ADDR_WIDTH-1:0];
              bit_cnt_d = '0;
              state_d   = rx_nxt[REG_WIDTH-1] ? S_DATA : S_RDLOAD;
            end
          end
        end
        S_RDLOAD: begin
          if (bus.spi_cs_n) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            tx_d    = bus.rd_data;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (bus.spi_cs_n) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else if (smp) begin
            rx_d      = rx_nxt;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (last) begin
              state_d = S_DONE;
              if (rw_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_nxt;
              end
            end
          end else if (sft && bit_cnt_q != '0) begin
            // No shift before the first sample keeps the MSB on the line.
            tx_d = tx_q << 1;
          end
        end
        S_DONE: begin
          if (bus.spi_cs_n) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.spi_miso  = tx_q[REG_WIDTH-1] & ~rw_q &
                         (state_q inside {S_RDLOAD, S_DATA, S_DONE});
  assign bus.wr_en     = wr_en_q & ena;
  assign bus.frame_err = err_q & ena;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_spi_frame_engine.sv
// Bench for spi_frame_engine: directed and random SPI frames in all
// four modes against a frame-level reference model.
module tb_spi_frame_engine;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] mode;

  always #5 clk = ~clk;

  spi_frame_engine_if bus ();

  spi_frame_engine dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .mode (mode),
    .bus  (bus)
  );

  logic [7:0] status_mem [16];
  always_comb bus.rd_data = status_mem[bus.rd_addr];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int miso_hi = 0;
  logic [3:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  logic [3:0] m_wa = '0;
  logic [7:0] m_wd = '0;
  logic [3:0] m_ra = '0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      last_wa = bus.wr_addr;
      last_wd = bus.wr_data;
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.spi_miso === 1'b1) miso_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master: bit i of the frame is tx[23-i]; miso sample lands in rx[23-i].
  task automatic spi_frame(input logic [1:0] m, input logic [23:0] tx,
                           input int nbits, input bit hold_cs,
                           output logic [23:0] rx);
    rx = '0;
    mode = m;
    bus.spi_clk = m[1];
    wait_clk(4);
    bus.spi_cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        bus.spi_mosi = tx[23-i];
        wait_clk(H);
        rx[23-i] = bus.spi_miso;
        bus.spi_clk = ~m[1];
        wait_clk(H);
        bus.spi_clk = m[1];
      end else begin
        bus.spi_clk = ~m[1];
        bus.spi_mosi = tx[23-i];
        wait_clk(H);
        rx[23-i] = bus.spi_miso;
        bus.spi_clk = m[1];
        wait_clk(H);
      end
    end
    wait_clk(H);
    if (!hold_cs) begin
      bus.spi_cs_n = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] cmd,
                           input logic [7:0] data, input int nbits,
                           input bit en);
    int w0, e0, h0;
    bit exp_wr, exp_err, is_wr;
    logic [7:0]  stat;
    logic [23:0] rx, mask, exp_rx;
    w0 = wr_cnt;
    e0 = err_cnt;
    h0 = miso_hi;
    is_wr = cmd[7];
    stat = status_mem[cmd[3:0]];
    spi_frame(m, {cmd, data, 8'($urandom)}, nbits, 1'b0, rx);
    exp_wr  = en && nbits >= 16 && is_wr;
    exp_err = en && nbits < 16;
    if (en && nbits >= 8) m_ra = cmd[3:0];
    if (exp_wr) begin
      m_wa = cmd[3:0];
      m_wd = data;
    end
    mask = '0;
    for (int i = 0; i < 16; i++) if (i < nbits) mask[23-i] = 1'b1;
    exp_rx = '0;
    if (!is_wr && en) exp_rx[15:8] = stat;
    check("wr_count", 32'(wr_cnt - w0), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr_strobe", 32'(last_wa), 32'(cmd[3:0]));
      check("wr_data_strobe", 32'(last_wd), 32'(data));
    end
    check("frame_err", 32'(err_cnt - e0), 32'(exp_err));
    check("wr_addr", 32'(bus.wr_addr), 32'(m_wa));
    check("wr_data", 32'(bus.wr_data), 32'(m_wd));
    check("rd_addr", 32'(bus.rd_addr), 32'(m_ra));
    check("miso_bits", 32'(rx & mask), 32'(exp_rx & mask));
    if (is_wr || !en) check("miso_quiet", 32'(miso_hi - h0), 32'd0);
    check("miso_idle", 32'(bus.spi_miso), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
  endtask

  initial begin
    logic [23:0] rx;
    int w0, e0, nb, r;
    logic [1:0] m;
    rst = 1'b1;
    ena = 1'b1;
    mode = 2'd0;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk = 1'b0;
    bus.spi_mosi = 1'b0;
    for (int i = 0; i < 16; i++) status_mem[i] = 8'($urandom);
    status_mem[2] = 8'hAA;
    status_mem[0] = 8'hCA;
    wait_clk(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    run_frame(2'd0, 8'h83, 8'hA5, 16, 1'b1);
    run_frame(2'd3, 8'h83, 8'hA5, 16, 1'b1);
    run_frame(2'd1, 8'h8F, 8'h3C, 16, 1'b1);
    run_frame(2'd2, 8'h8F, 8'h3C, 16, 1'b1);
    run_frame(2'd1, 8'h02, 8'h00, 16, 1'b1);
    run_frame(2'd0, 8'h00, 8'h00, 24, 1'b1);
    run_frame(2'd0, 8'h81, 8'hF0, 13, 1'b1);
    run_frame(2'd0, 8'h81, 8'h11, 16, 1'b1);
    run_frame(2'd3, 8'h05, 8'h00, 8, 1'b1);
    run_frame(2'd2, 8'h86, 8'h00, 4, 1'b1);

    ena = 1'b0;
    run_frame(2'd0, 8'h87, 8'h77, 16, 1'b0);
    ena = 1'b1;
    wait_clk(2);
    run_frame(2'd0, 8'h87, 8'h77, 16, 1'b1);

    // Reset in the middle of a command byte with cs_n still low.
    spi_frame(2'd0, 24'h845A00, 4, 1'b1, rx);
    rst = 1'b1;
    wait_clk(3);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    m_wa = '0;
    m_wd = '0;
    m_ra = '0;
    w0 = wr_cnt;
    e0 = err_cnt;
    repeat (10) begin
      bus.spi_mosi = 1'($urandom);
      bus.spi_clk = 1'b1;
      wait_clk(H);
      bus.spi_clk = 1'b0;
      wait_clk(H);
    end
    bus.spi_cs_n = 1'b1;
    wait_clk(4);
    check("post_reset_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("post_reset_no_err", 32'(err_cnt - e0), 32'd0);
    check_reset_outputs("post_reset");
    run_frame(2'd0, 8'h84, 8'h5A, 16, 1'b1);

    for (int k = 0; k < 24; k++) begin
      m = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 5);
      nb = (r < 3) ? 16 : (r == 3) ? 24 : $urandom_range(1, 15);
      run_frame(m, 8'($urandom), 8'($urandom), nb, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
